acumulador_moedas: RTL and testbench

- Coin-accumulation and purchase-request stage of the vending machine.
- Sits directly upstream of the price comparator.
- Decodes and sums inserted coins, latches the selected product on confirm, then presents `valorMoedas`, `valorProduto` and `enable` to the comparator until it answers with `fim`.
- Also handles user cancel and coin rejection, and clears itself for the next sale.

---
 rtl/maquina_pkg.sv | 23 ++
 rtl/acumulador_moedas_decodificador.sv | 25 ++
 rtl/acumulador_moedas.sv | 182 ++++++++++++++++++
 tb/tb_acumulador_moedas.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/maquina_pkg.sv
// Shared types and constants for the vending-machine coin stage.
//   estado_t        : controller states of acumulador_moedas
//   MOEDA_*         : coin codes carried on moeda_codigo
//   LARG_VALOR/PROD : widths of the running total and product code
package maquina_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    ACUMULANDO,
    AVALIAR,
    CONCLUIR,
    DEVOLVER
  } estado_t;

  localparam logic [1:0] MOEDA_1   = 2'b00;
  localparam logic [1:0] MOEDA_2   = 2'b01;
  localparam logic [1:0] MOEDA_4   = 2'b10;
  localparam logic [1:0] MOEDA_INV = 2'b11;

  localparam int unsigned LARG_VALOR = 4;
  localparam int unsigned LARG_PROD  = 3;

endpackage

// File: rtl/acumulador_moedas_decodificador.sv
// Coin decoder: maps a 2-bit coin code to its value in coin units.
//   codigo_i : coin code (MOEDA_1 / MOEDA_2 / MOEDA_4 / MOEDA_INV)
//   valor_o  : coin value, 0 for the invalid code
//   valida_o : high when the code names a real coin
module decodificador_moeda
  import maquina_pkg::*;
(
  input  logic [1:0]            codigo_i,
  output logic [LARG_VALOR-1:0] valor_o,
  output logic                  valida_o
);

  always_comb begin
    valor_o  = '0;
    valida_o = 1'b1;
    unique case (codigo_i)
      MOEDA_1:   valor_o = LARG_VALOR'(1);
      MOEDA_2:   valor_o = LARG_VALOR'(2);
      MOEDA_4:   valor_o = LARG_VALOR'(4);
      MOEDA_INV: valida_o = 1'b0;
      default:   valida_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/acumulador_moedas.sv
// Coin accumulation and purchase-request stage of the vending machine.
// Sums accepted coins, latches the product on confirmar, then holds
// enable towards the price comparator until it answers with fim.
// All outputs are registered.
//   clk, rst_n        : clock, asynchronous active-low reset
//   moeda_valida/codigo : coin strobe and code
//   produto_sel, confirmar, cancelar : purchase request / abort pulses
//   fim               : comparator done
//   valorMoedas, valorProduto, enable : comparator interface
//   moeda_rejeitada, devolver_cancel, concluido, timeout_ocorrido : pulses
//   ocupado           : state is not OCIOSO
// Optional: define ACUMULADOR_TIMEOUT_EN to auto-cancel after
// TIMEOUT_CICLOS idle cycles in ACUMULANDO.
module acumulador_moedas
  import maquina_pkg::*;
#(
  parameter int unsigned VALOR_MAX      = 15,
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 moeda_valida,
  input  logic [1:0]           moeda_codigo,
  input  logic [LARG_PROD-1:0] produto_sel,
  input  logic                 confirmar,
  input  logic                 cancelar,
  input  logic                 fim,
  output logic [LARG_VALOR-1:0] valorMoedas,
  output logic [LARG_PROD-1:0] valorProduto,
  output logic                 enable,
  output logic                 moeda_rejeitada,
  output logic                 devolver_cancel,
  output logic                 concluido,
  output logic                 ocupado,
  output logic                 timeout_ocorrido
);

  if (VALOR_MAX > 15 || TIMEOUT_CICLOS < 2) begin : g_param_invalido
    $error("acumulador_moedas: VALOR_MAX must be <= 15 and TIMEOUT_CICLOS >= 2");
  end

  estado_t               estado_q, estado_d;
  logic [LARG_VALOR-1:0] valorMoedas_q, valorMoedas_d;
  logic [LARG_PROD-1:0]  valorProduto_q, valorProduto_d;
  logic                  enable_q, enable_d;
  logic                  rejeitada_q, rejeitada_d;
  logic                  devolver_q, devolver_d;
  logic                  concluido_q, concluido_d;
  logic                  ocupado_q, ocupado_d;
  logic                  timeout_q, timeout_d;

  logic [LARG_VALOR-1:0] valor_moeda;
  logic                  codigo_ok;
  logic [LARG_VALOR:0]   soma;
  logic                  moeda_cabe;
  logic                  aceita;
  logic                  timeout_fim;

  decodificador_moeda u_decod (
    .codigo_i (moeda_codigo),
    .valor_o  (valor_moeda),
    .valida_o (codigo_ok)
  );

  // One extra bit so an overflowing sum is refused instead of wrapping.
  assign soma       = {1'b0, valorMoedas_q} + {1'b0, valor_moeda};
  assign moeda_cabe = moeda_valida && codigo_ok &&
                      (soma <= (LARG_VALOR+1)'(VALOR_MAX));

`ifdef ACUMULADOR_TIMEOUT_EN
  localparam int unsigned LARG_CNT = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  logic [LARG_CNT-1:0] cnt_q, cnt_d;

  assign timeout_fim = (estado_q == ACUMULANDO) &&
                       (cnt_q == LARG_CNT'(TIMEOUT_CICLOS - 1));

  // Held at zero outside ACUMULANDO, so entering the state starts a fresh count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (estado_q != ACUMULANDO || aceita) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_fim = 1'b0;
`endif

  always_comb begin
    estado_d       = estado_q;
    valorMoedas_d  = valorMoedas_q;
    valorProduto_d = valorProduto_q;
    enable_d       = 1'b0;
    devolver_d     = 1'b0;
    concluido_d    = 1'b0;
    timeout_d      = 1'b0;
    aceita         = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (moeda_cabe) begin
          aceita        = 1'b1;
          valorMoedas_d = soma[LARG_VALOR-1:0];
          estado_d      = ACUMULANDO;
        end
      end
      ACUMULANDO: begin
        if (cancelar) begin
          devolver_d = 1'b1;
          estado_d   = DEVOLVER;
        end else if (confirmar) begin
          valorProduto_d = produto_sel;
          estado_d       = AVALIAR;
        end else if (moeda_cabe) begin
          aceita        = 1'b1;
          valorMoedas_d = soma[LARG_VALOR-1:0];
        end else if (timeout_fim) begin
          devolver_d = 1'b1;
          timeout_d  = 1'b1;
          estado_d   = DEVOLVER;
        end
      end
      AVALIAR: begin
        if (fim) begin
          concluido_d    = 1'b1;
          valorMoedas_d  = '0;
          valorProduto_d = '0;
          estado_d       = CONCLUIR;
        end else begin
          enable_d = 1'b1;
        end
      end
      CONCLUIR: estado_d = OCIOSO;
      DEVOLVER: begin
        valorMoedas_d = '0;
        estado_d      = OCIOSO;
      end
      default: begin
        valorMoedas_d  = '0;
        valorProduto_d = '0;
        estado_d       = OCIOSO;
      end
    endcase
    rejeitada_d = moeda_valida && !aceita;
    ocupado_d   = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= OCIOSO;
      valorMoedas_q  <= '0;
      valorProduto_q <= '0;
      enable_q       <= 1'b0;
      rejeitada_q    <= 1'b0;
      devolver_q     <= 1'b0;
      concluido_q    <= 1'b0;
      ocupado_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      valorMoedas_q  <= valorMoedas_d;
      valorProduto_q <= valorProduto_d;
      enable_q       <= enable_d;
      rejeitada_q    <= rejeitada_d;
      devolver_q     <= devolver_d;
      concluido_q    <= concluido_d;
      ocupado_q      <= ocupado_d;
      timeout_q      <= timeout_d;
    end
  end

  assign valorMoedas      = valorMoedas_q;
  assign valorProduto     = valorProduto_q;
  assign enable           = enable_q;
  assign moeda_rejeitada  = rejeitada_q;
  assign devolver_cancel  = devolver_q;
  assign concluido        = concluido_q;
  assign ocupado          = ocupado_q;
  assign timeout_ocorrido = timeout_q;

endmodule

// File: tb/tb_acumulador_moedas.sv
// Bench for acumulador_moedas: per-cycle stimulus/expected-output table,
// plus hand-written reset-in-AVALIAR and idle-timeout sequences.
// Expected outputs are packed as {vm[4], vp[3], en, rej, dev, conc, ocup, tmo}.
module tb_acumulador_moedas;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       moeda_valida;
  logic [1:0] moeda_codigo;
  logic [2:0] produto_sel;
  logic       confirmar, cancelar, fim;
  logic [3:0] valorMoedas;
  logic [2:0] valorProduto;
  logic       enable, moeda_rejeitada, devolver_cancel, concluido, ocupado, timeout_ocorrido;

  int n_comp = 0;
  int n_err  = 0;

  acumulador_moedas #(.VALOR_MAX(15), .TIMEOUT_CICLOS(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .moeda_valida     (moeda_valida),
    .moeda_codigo     (moeda_codigo),
    .produto_sel      (produto_sel),
    .confirmar        (confirmar),
    .cancelar         (cancelar),
    .fim              (fim),
    .valorMoedas      (valorMoedas),
    .valorProduto     (valorProduto),
    .enable           (enable),
    .moeda_rejeitada  (moeda_rejeitada),
    .devolver_cancel  (devolver_cancel),
    .concluido        (concluido),
    .ocupado          (ocupado),
    .timeout_ocorrido (timeout_ocorrido)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nome;
    logic       mv;
    logic [1:0] mc;
    logic [2:0] ps;
    logic       conf, canc, fim;
    logic [13:0] esperado;
  } vec_t;

  vec_t tab[$];
  vec_t sb[$];

  function automatic vec_t mk(string nome, logic mv, logic [1:0] mc, logic [2:0] ps,
                              logic conf, logic canc, logic f,
                              logic [3:0] vm, logic [2:0] vp, logic en, logic rej,
                              logic dev, logic conc, logic ocup, logic tmo);
    vec_t v;
    v.nome = nome; v.mv = mv; v.mc = mc; v.ps = ps;
    v.conf = conf; v.canc = canc; v.fim = f;
    v.esperado = {vm, vp, en, rej, dev, conc, ocup, tmo};
    return v;
  endfunction

  function automatic logic [13:0] saidas();
    return {valorMoedas, valorProduto, enable, moeda_rejeitada,
            devolver_cancel, concluido, ocupado, timeout_ocorrido};
  endfunction

  task automatic compara(input string nome, input logic [13:0] obtido, input logic [13:0] esp);
    n_comp++;
    if (obtido !== esp) begin
      n_err++;
      $display("FAIL %s: got vm=%0d vp=%0d en/rej/dev/conc/ocup/tmo=%b, expected vm=%0d vp=%0d en/rej/dev/conc/ocup/tmo=%b",
               nome, obtido[13:10], obtido[9:7], obtido[5:0], esp[13:10], esp[9:7], esp[5:0]);
    end
  endtask

  task automatic aplica(input vec_t v);
    vec_t e;
    @(negedge clk);
    moeda_valida = v.mv; moeda_codigo = v.mc; produto_sel = v.ps;
    confirmar = v.conf; cancelar = v.canc; fim = v.fim;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compara(e.nome, saidas(), e.esperado);
  endtask

  task automatic ocioso_entradas();
    moeda_valida = 1'b0; moeda_codigo = 2'b00; produto_sel = 3'b000;
    confirmar = 1'b0; cancelar = 1'b0; fim = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ocioso_entradas();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compara("reset", saidas(), 14'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //        nome            mv mc  ps conf canc fim  vm vp en rej dev conc ocup tmo
    // Purchase 2+2, product 010
    tab.push_back(mk("A moeda2",   1, 1, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("A moeda2b",  1, 1, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("A confirma", 0, 0, 2, 1, 0, 0,   4, 2, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("A enable",   0, 0, 0, 0, 0, 0,   4, 2, 1, 0, 0, 0, 1, 0));
    tab.push_back(mk("A fim",      0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 1, 0));
    tab.push_back(mk("A ocioso",   0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    // Saturation at 12 and 15
    tab.push_back(mk("B m4a",      1, 2, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("B m4b",      1, 2, 0, 0, 0, 0,   8, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("B m4c",      1, 2, 0, 0, 0, 0,  12, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("B m4 rej",   1, 2, 0, 0, 0, 0,  12, 0, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk("B m1a",      1, 0, 0, 0, 0, 0,  13, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("B m1b",      1, 0, 0, 0, 0, 0,  14, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("B m1c",      1, 0, 0, 0, 0, 0,  15, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("B m1 rej",   1, 0, 0, 0, 0, 0,  15, 0, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk("B cancela",  0, 0, 0, 0, 1, 0,  15, 0, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk("B limpo",    0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    // 14 + 2 overflows the 4-bit total
    tab.push_back(mk("F m4a",      1, 2, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("F m4b",      1, 2, 0, 0, 0, 0,   8, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("F m4c",      1, 2, 0, 0, 0, 0,  12, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("F m2",       1, 1, 0, 0, 0, 0,  14, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("F m2 rej",   1, 1, 0, 0, 0, 0,  14, 0, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk("F cancela",  0, 0, 0, 0, 1, 0,  14, 0, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk("F limpo",    0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    // cancelar beats confirmar
    tab.push_back(mk("C m2",       1, 1, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("C canc+conf",0, 0, 3, 1, 1, 0,   2, 0, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk("C limpo",    0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    // OCIOSO: invalid coin, confirmar and cancelar do nothing
    tab.push_back(mk("D cod11",    1, 3, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk("D confirma", 0, 0, 7, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk("D cancela",  0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0));
    // Coin with confirmar is refused; AVALIAR holds while fim stays low
    tab.push_back(mk("E m4",       1, 2, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk("E conf+moeda",1,0, 5, 1, 0, 0,   4, 5, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk("E enable",   0, 0, 0, 0, 0, 0,   4, 5, 1, 0, 0, 0, 1, 0));
    tab.push_back(mk("E w1 moeda", 1, 0, 0, 0, 0, 0,   4, 5, 1, 1, 0, 0, 1, 0));
    tab.push_back(mk("E w2 canc",  0, 0, 0, 0, 1, 0,   4, 5, 1, 0, 0, 0, 1, 0));
    tab.push_back(mk("E w3 moeda", 1, 1, 0, 0, 0, 0,   4, 5, 1, 1, 0, 0, 1, 0));
    tab.push_back(mk("E w4 conf",  1, 2, 1, 1, 0, 0,   4, 5, 1, 1, 0, 0, 1, 0));
    tab.push_back(mk("E w5 canc",  1, 0, 0, 0, 1, 0,   4, 5, 1, 1, 0, 0, 1, 0));

    for (int i = 0; i < tab.size(); i++) aplica(tab[i]);

    // Asynchronous reset while waiting in AVALIAR
    @(negedge clk);
    ocioso_entradas();
    rst_n = 1'b0;
    #1;
    compara("reset async", saidas(), 14'd0);
    @(posedge clk);
    #1;
    compara("reset mantido", saidas(), 14'd0);
    @(negedge clk);
    rst_n = 1'b1;
    aplica(mk("G pos-reset", 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));

    // One coin, then idle in ACUMULANDO
    aplica(mk("T moeda",       1, 2, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 1, 0));
`ifdef ACUMULADOR_TIMEOUT_EN
    for (int i = 1; i <= 7; i++)
      aplica(mk("T espera",    0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 1, 0));
    aplica(mk("T timeout",     0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 1, 0, 1, 1));
    aplica(mk("T limpo",       0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
`else
    for (int i = 1; i <= 12; i++)
      aplica(mk("T espera",    0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 1, 0));
    aplica(mk("T cancela",     0, 0, 0, 0, 1, 0,   4, 0, 0, 0, 1, 0, 1, 0));
    aplica(mk("T limpo",       0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
    $finish;
  end

endmodule
